inst_fetcher: RTL and testbench
===============================

// Module: inst_fetcher
// PURPOSE
//  Front end of the core, directly upstream of the decoder. Owns the PC, fetches one 32-bit
//  instruction at a time from the ICache, statically predicts the next PC, and buffers
//  {inst, pc, pred_pc} in a circular instruction queue. The queue head is presented to the
//  decoder/dispatch stage. A misprediction flush from the ROB empties the queue and redirects the PC.
// PARAMETERS
//  IQ_LOG    4           log2 of queue depth (DEPTH = 2**IQ_LOG = 16)
//  RESET_PC  32'h0       PC loaded at reset
// PORTS
//  clk_in            in   1   clock; all state updates on rising edge
//  rst_n_in          in   1   reset, asynchronous, active-low
//  rdy_in            in   1   global ready; low freezes every register (flush included)
//  icache_req_valid  out  1   fetch request pending (level, held until response)
//  icache_req_addr   out  32  address of the pending fetch
//  icache_resp_valid in   1   one-cycle pulse: icache_resp_inst valid for icache_req_addr
//  icache_resp_inst  in   32  fetched instruction
//  flush_in          in   1   misprediction redirect
//  flush_pc_in       in   32  correct PC after flush
//  deq_ready_in      in   1   downstream accepts the head entry this cycle
//  out_valid         out  1   queue non-empty
//  out_inst          out  32  head instruction
//  out_pc            out  32  head instruction PC
//  out_pred_pc       out  32  predicted next PC of head instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, head=tail=count=0, discard=0, icache_req_valid=0,
//   icache_req_addr=0, out_valid=0; out_inst/out_pc/out_pred_pc read 0 (storage cleared).
//  rdy_in=0: all registers hold. ICache never pulses icache_resp_valid while rdy_in=0.
//  FSM (2 states):
//   IDLE: if !flush_in && count<DEPTH -> icache_req_addr<=pc, state<=WAIT. Else stay.
//   WAIT: icache_req_valid=1 (combinational from state). On icache_resp_valid:
//     if discard=0 and !flush_in: push {inst, icache_req_addr, pred} at tail, pc<=pred.
//     state<=IDLE, discard<=0 in all cases.
//  Prediction: opcode 7'b1101111 (JAL) -> pred = req_addr + J-imm
//   ({{12{i[31]}},i[19:12],i[20],i[30:21],1'b0}); all other opcodes -> req_addr+4. 32-bit wrap.
//  Request gating at count<DEPTH guarantees room: only one fetch in flight, pops only free space.
//  Queue: out_* combinationally driven from entry[head]; out_valid=(count!=0).
//   Pop when out_valid && deq_ready_in. head/tail increment modulo DEPTH (wrap 15->0).
//   Push+pop same cycle: count unchanged, both pointers advance.
//  Latency: response at edge N -> entry visible on out_* after edge N; next request issues
//   at edge N+1 earliest (IDLE cycle between fetches).
//  Flush (priority over push/pop/request): head=tail=count=0, pc<=flush_pc_in, same edge.
//   If WAIT with no response this cycle: stay WAIT, discard<=1, req_addr unchanged
//   (cache cannot abort); later response dropped, then IDLE fetches flush_pc.
//   Flush coincident with response: response dropped, state<=IDLE, discard stays 0.
//   Flush in IDLE: no request that cycle.
//  Reset mid-fetch: state, queue and discard cleared at once; late response ignored (IDLE).
// TESTING
//  1 Reset, rdy=1: out_valid=0; cycle after release icache_req_valid=1, addr=0x0.
//  2 Resp 0x00000013 at addrs 0,4,8, deq_ready=1 -> out_pc 0,4,8; out_pred_pc 4,8,0xC.
//  3 pc=0x10, resp 0x1000006F (jal x0,256) -> out_pred_pc=0x110; next req addr=0x110.
//  4 deq_ready=0, 16 responses -> count=16, req_valid stays 0; one pop -> new request.
//  5 Flush (flush_pc=0x200) while WAIT at 0x40 -> out_valid=0 next cycle; 0x40 resp
//    dropped; next request addr=0x200.
//  6 Push+pop with tail/head at 15 -> pointers wrap to 0, count const, order preserved.

Source files
------------

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: owns the PC, fetches one instruction at a time from the
// ICache, predicts the next PC statically and queues {inst, pc, pred_pc} for the decoder.
module inst_fetcher #(
  parameter int          IQ_LOG   = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_inst,
  input  logic        flush_in,
  input  logic [31:0] flush_pc_in,
  input  logic        deq_ready_in,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pred_pc
);

  localparam int DEPTH = 2 ** IQ_LOG;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_discard;
  logic                w_discard_nxt;
  logic [31:0]         r_pc;
  logic [31:0]         r_req_addr;
  logic [IQ_LOG-1:0]   r_head;
  logic [IQ_LOG-1:0]   r_tail;
  logic [IQ_LOG:0]     r_count;
  logic [31:0]         r_inst_mem [DEPTH];
  logic [31:0]         r_pc_mem   [DEPTH];
  logic [31:0]         r_pred_mem [DEPTH];

  logic                w_full;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic [31:0]         w_jimm;
  logic [31:0]         w_pred;

  assign w_full  = r_count[IQ_LOG];
  assign w_jimm  = {{12{icache_resp_inst[31]}}, icache_resp_inst[19:12], icache_resp_inst[20],
                    icache_resp_inst[30:21], 1'b0};
  assign w_pred  = (icache_resp_inst[6:0] == 7'b1101111) ? (r_req_addr + w_jimm)
                                                         : (r_req_addr + 32'd4);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt      = r_state;
    w_discard_nxt    = r_discard;
    w_issue          = 1'b0;
    w_push           = 1'b0;
    icache_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush_in && !w_full) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        icache_req_valid = 1'b1;
        if (icache_resp_valid) begin
          w_push        = !r_discard && !flush_in;
          w_state_nxt   = S_IDLE;
          w_discard_nxt = 1'b0;
        end else if (flush_in) begin
          // The cache cannot abort an issued fetch, so its eventual response must be dropped.
          w_discard_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_pop = out_valid && deq_ready_in && !flush_in;

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= S_IDLE;
      r_discard  <= 1'b0;
      r_pc       <= RESET_PC;
      r_req_addr <= 32'h0;
    end else if (rdy_in) begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
      if (flush_in)     r_pc <= flush_pc_in;
      else if (w_push)  r_pc <= w_pred;
      if (w_issue)      r_req_addr <= r_pc;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_pop)  r_head <= r_head + IQ_LOG'(1);
        if (w_push) r_tail <= r_tail + IQ_LOG'(1);
        r_count <= r_count + {{IQ_LOG{1'b0}}, w_push} - {{IQ_LOG{1'b0}}, w_pop};
      end
    end
  end

  // NOTE: storage is reset so an empty queue presents zeros rather than X on out_*.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
        r_pred_mem[i] <= '0;
      end
    end else if (rdy_in && w_push) begin
      r_inst_mem[r_tail] <= icache_resp_inst;
      r_pc_mem[r_tail]   <= r_req_addr;
      r_pred_mem[r_tail] <= w_pred;
    end
  end

  assign icache_req_addr = r_req_addr;
  assign out_valid       = (r_count != '0);
  assign out_inst        = r_inst_mem[r_head];
  assign out_pc          = r_pc_mem[r_head];
  assign out_pred_pc     = r_pred_mem[r_head];

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: a queue-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        deq;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pred_pc;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  inst_fetcher #(.IQ_LOG(4), .RESET_PC(32'h0)) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .rdy_in            (rdy),
    .icache_req_valid  (req_valid),
    .icache_req_addr   (req_addr),
    .icache_resp_valid (resp_valid),
    .icache_resp_inst  (resp_inst),
    .flush_in          (flush),
    .flush_pc_in       (flush_pc),
    .deq_ready_in      (deq),
    .out_valid         (out_valid),
    .out_inst          (out_inst),
    .out_pc            (out_pc),
    .out_pred_pc       (out_pred_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of fetched entries plus "fetch outstanding" bookkeeping.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_addr = 32'h0;
  bit          m_busy = 1'b0;
  bit          m_disc = 1'b0;

  function automatic logic [31:0] predict(input logic [31:0] inst, input logic [31:0] addr);
    int off;
    if (inst[6:0] == 7'h6F) begin
      off = int'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      return addr + off;
    end
    return addr + 32'd4;
  endfunction

  initial forever begin : model
    ent_t e;
    int   pre_n;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_pc   = 32'h0;
      m_addr = 32'h0;
      m_busy = 1'b0;
      m_disc = 1'b0;
    end else if (rdy) begin
      pre_n = m_q.size();
      if (flush) begin
        m_q.delete();
        m_pc = flush_pc;
        if (m_busy) begin
          if (resp_valid) begin
            m_busy = 1'b0;
            m_disc = 1'b0;
          end else begin
            m_disc = 1'b1;
          end
        end
      end else begin
        if (pre_n > 0 && deq) void'(m_q.pop_front());
        if (m_busy) begin
          if (resp_valid) begin
            if (!m_disc) begin
              e.inst = resp_inst;
              e.pc   = m_addr;
              e.pred = predict(resp_inst, m_addr);
              m_q.push_back(e);
              m_pc = e.pred;
            end
            m_busy = 1'b0;
            m_disc = 1'b0;
          end
        end else if (pre_n < 16) begin
          m_busy = 1'b1;
          m_addr = m_pc;
        end
      end
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (chk_en && rst_n) begin
      check("req_valid", req_valid, m_busy);
      check("req_addr", req_addr, m_addr);
      check("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        check("out_inst", out_inst, m_q[0].inst);
        check("out_pc", out_pc, m_q[0].pc);
        check("out_pred_pc", out_pred_pc, m_q[0].pred);
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] inst, input bit fl,
                     input logic [31:0] fpc, input bit dq);
    resp_valid = v;
    resp_inst  = inst;
    flush      = fl;
    flush_pc   = fpc;
    deq        = dq;
    @(posedge clk);
    #1;
    resp_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic wait_req(input bit dq);
    int n = 0;
    while (!req_valid && n < 40) begin
      cyc(1'b0, 32'h0, 1'b0, 32'h0, dq);
      n++;
    end
    if (!req_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout: got no request within %0d cycles, required a request", n);
    end
  endtask

  task automatic fetch(input logic [31:0] inst, input bit dq_wait, input bit dq_resp);
    wait_req(dq_wait);
    cyc(1'b1, inst, 1'b0, 32'h0, dq_resp);
  endtask

  initial begin
    rst_n      = 1'b0;
    rdy        = 1'b1;
    resp_valid = 1'b0;
    resp_inst  = 32'h0;
    flush      = 1'b0;
    flush_pc   = 32'h0;
    deq        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_pred", out_pred_pc, 32'h0);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_req_addr", req_addr, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("first_req_valid", req_valid, 1'b1);
    check("first_req_addr", req_addr, 32'h0);

    // Sequential fetches with the decoder always ready
    for (int i = 0; i < 3; i++) begin
      fetch(32'h0000_0013, 1'b1, 1'b1);
      check("seq_out_valid", out_valid, 1'b1);
      check("seq_out_pc", out_pc, 32'(4 * i));
      check("seq_out_pred", out_pred_pc, 32'(4 * i + 4));
    end

    // JAL prediction at 0x10
    fetch(32'h0000_0013, 1'b1, 1'b1);
    fetch(32'h1000_006F, 1'b1, 1'b1);
    check("jal_out_pc", out_pc, 32'h10);
    check("jal_out_pred", out_pred_pc, 32'h110);
    wait_req(1'b1);
    check("jal_next_addr", req_addr, 32'h110);

    // Fill the queue with the decoder stalled
    for (int i = 0; i < 16; i++) begin
      fetch((i % 4 == 3) ? 32'hFF1F_F06F : (32'h0000_0013 | (32'(i) << 20)), 1'b0, 1'b0);
      if (i == 3) begin
        wait_req(1'b0);
        check("jal_back_addr", req_addr, 32'h10C);
      end
    end
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("full_no_req", req_valid, 1'b0);
    check("full_head_pc", out_pc, 32'h110);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("pop_edge_no_req", req_valid, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("after_pop_req", req_valid, 1'b1);

    // Flush while a fetch is outstanding, then park a fetch in flight at 0x40
    cyc(1'b0, 32'h0, 1'b1, 32'h3C, 1'b0);
    check("flush1_out_valid", out_valid, 1'b0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    check("drop1_out_valid", out_valid, 1'b0);
    fetch(32'h0000_0013, 1'b0, 1'b0);
    wait_req(1'b0);
    check("wait40_addr", req_addr, 32'h40);
    check("wait40_out_valid", out_valid, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    check("flush2_out_valid", out_valid, 1'b0);
    check("flush2_still_wait", req_valid, 1'b1);
    check("flush2_addr_held", req_addr, 32'h40);
    cyc(1'b1, 32'h1234_5013, 1'b0, 32'h0, 1'b0);
    check("drop2_out_valid", out_valid, 1'b0);
    wait_req(1'b0);
    check("redirect_addr", req_addr, 32'h200);

    // Flush coincident with a response
    cyc(1'b1, 32'h0000_0013, 1'b1, 32'h300, 1'b0);
    check("coinc_out_valid", out_valid, 1'b0);
    check("coinc_idle", req_valid, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("coinc_req_addr", req_addr, 32'h300);

    // Flush in IDLE blocks that cycle's request
    cyc(1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
    check("idle_flush_no_req", req_valid, 1'b0);
    check("idle_flush_empty", out_valid, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("idle_flush_addr", req_addr, 32'h400);

    // rdy low freezes everything, pop requests included
    fetch(32'h0000_0013, 1'b0, 1'b0);
    rdy = 1'b0;
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("frozen_out_valid", out_valid, 1'b1);
    check("frozen_req_valid", req_valid, 1'b0);
    check("frozen_out_pc", out_pc, 32'h400);
    rdy = 1'b1;

    // Pointer wrap with simultaneous push and pop
    cyc(1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) fetch(32'h0000_0013, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    fetch(32'h0000_0013, 1'b0, 1'b0);
    check("slot15_pc", out_pc, 32'h3C);
    fetch(32'h0000_0013, 1'b0, 1'b1);
    check("wrap1_out_valid", out_valid, 1'b1);
    check("wrap1_pc", out_pc, 32'h40);
    fetch(32'h0000_0013, 1'b0, 1'b1);
    check("wrap2_pc", out_pc, 32'h44);

    // Reset in the middle of a fetch; the late response must be ignored
    wait_req(1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_req_valid", req_valid, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
    check("late_resp_ignored", out_valid, 1'b0);
    check("post_rst_req", req_valid, 1'b1);
    check("post_rst_addr", req_addr, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
